// File: rtl/op_pkg.sv
// Shared definitions for the op_integrator slice: default width,
// controller state encoding and signed saturation limits.
package op_pkg;

  // Default sample / accumulator width in bits (two's complement).
  localparam int WIDTH_DEFAULT = 19;

  // Signed saturation limits at the default width.
  localparam logic signed [WIDTH_DEFAULT-1:0] SAT_MAX = {1'b0, {(WIDTH_DEFAULT-1){1'b1}}};
  localparam logic signed [WIDTH_DEFAULT-1:0] SAT_MIN = {1'b1, {(WIDTH_DEFAULT-1){1'b0}}};

  // Controller states: wait for a frame, step through stages, publish result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/op_sat_adder.sv
// Combinational shared adder for the integrator stages.
// Optional feature macro: OP_INTEGRATOR_SAT_EN -- when defined the sum clamps
// to the signed range of WIDTH bits; otherwise it wraps modulo 2^WIDTH.
module op_sat_adder
  import op_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] sum
);

`ifdef OP_INTEGRATOR_SAT_EN
  localparam logic signed [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH:0] wide_sum;

  // One guard bit exposes overflow; clamp toward the sign of the true result.
  always_comb begin
    wide_sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (wide_sum[WIDTH] != wide_sum[WIDTH-1]) begin
      sum = wide_sum[WIDTH] ? MIN_VAL : MAX_VAL;
    end else begin
      sum = wide_sum[WIDTH-1:0];
    end
  end
`else
  // Plain two's complement wrap.
  assign sum = a + b;
`endif

endmodule

// File: rtl/op_integrator.sv
// Cascaded integrator: each frame strobe captures one sample, then the stages
// are updated one per cycle through a single shared adder, and the last stage
// is published on out with a one-cycle out_valid pulse.
// Optional feature macro: OP_INTEGRATOR_SAT_EN (saturating stage additions).
module op_integrator
  import op_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter int STAGES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    lr_clk,
  input  logic signed [WIDTH-1:0] in,
  output logic signed [WIDTH-1:0] out,
  output logic                    out_valid,
  output logic                    overrun
);

  localparam int KW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(STAGES - 1);

  state_t                  state_reg, state_next;
  logic [KW-1:0]           k_reg;
  logic                    prev_lr_clk_reg;
  logic signed [WIDTH-1:0] sample_reg;
  logic signed [WIDTH-1:0] out_reg;
  logic                    out_valid_reg;
  logic                    overrun_reg;
  logic signed [WIDTH-1:0] acc_reg [STAGES];
  logic signed [WIDTH-1:0] addend  [STAGES];
  logic signed [WIDTH-1:0] sum;
  logic                    frame_start;
  logic                    capture;
  logic                    step;
  logic                    finish;

  assign frame_start = lr_clk & ~prev_lr_clk_reg;

  // Stage 0 integrates the captured sample; stage k integrates stage k-1,
  // which has already been refreshed earlier in the same frame.
  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_addend
      if (gi == 0) begin : g_first
        assign addend[gi] = sample_reg;
      end else begin : g_chain
        assign addend[gi] = acc_reg[gi-1];
      end
    end
  endgenerate

  op_sat_adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a  (acc_reg[k_reg]),
    .b  (addend[k_reg]),
    .sum(sum)
  );

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (frame_start) begin
          capture    = 1'b1;
          state_next = ACC;
        end
      end
      ACC: begin
        step = 1'b1;
        if (k_reg == K_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: edge history, sample capture, stage updates, output and overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_lr_clk_reg <= 1'b0;
      k_reg           <= '0;
      sample_reg      <= '0;
      out_reg         <= '0;
      out_valid_reg   <= 1'b0;
      overrun_reg     <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        acc_reg[i] <= '0;
      end
    end else begin
      prev_lr_clk_reg <= lr_clk;
      out_valid_reg   <= finish;
      if (capture) begin
        sample_reg <= in;
        k_reg      <= '0;
      end
      if (step) begin
        acc_reg[k_reg] <= sum;
        k_reg          <= k_reg + 1'b1;
      end
      if (finish) begin
        out_reg <= acc_reg[STAGES-1];
      end
      // A new frame arriving while busy is discarded; the flag stays set.
      if (frame_start && (state_reg != IDLE)) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_op_integrator.sv
// Self-checking bench for op_integrator (WIDTH=19, STAGES=3) with a
// frame-level reference model; honours OP_INTEGRATOR_SAT_EN when defined.
module tb_op_integrator;
  import op_pkg::*;

  localparam int W    = 19;
  localparam int S    = 3;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));
  localparam int LAT  = S + 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                lr_clk = 1'b0;
  logic signed [W-1:0] in_s = '0;
  logic signed [W-1:0] out_s;
  logic                out_valid;
  logic                overrun;

  int checks = 0;
  int errors = 0;
  int macc[S];

  always #5 clk = ~clk;

  op_integrator #(.WIDTH(W), .STAGES(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .lr_clk   (lr_clk),
    .in       (in_s),
    .out      (out_s),
    .out_valid(out_valid),
    .overrun  (overrun)
  );

  // Reduce an exact integer sum to what a WIDTH-bit stage holds.
  function automatic int fit(longint v);
    longint m;
`ifdef OP_INTEGRATOR_SAT_EN
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return int'(v);
`else
    m = v & ((64'sd1 <<< W) - 1);
    if (m > MAXV) m = m - (64'sd1 <<< W);
    return int'(m);
`endif
  endfunction

  // One frame of a cascaded integrator: each stage accumulates its input.
  function automatic int model_frame(int x);
    longint feed;
    feed = x;
    for (int s = 0; s < S; s++) begin
      macc[s] = fit(longint'(macc[s]) + feed);
      feed = macc[s];
    end
    return macc[S-1];
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < S; s++) macc[s] = 0;
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    lr_clk = 1'b0;
    in_s = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Assumes the strobe has just been raised at a falling edge; waits for
  // the result, checks latency, value, single-cycle pulse and hold.
  task automatic wait_result(input int exp, input string name, output int got);
    bit seen;
    int lat;
    seen = 1'b0;
    lat = 0;
    got = 0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) lr_clk = 1'b0;
      if (out_valid) begin
        seen = 1'b1;
        lat = n;
        got = int'(out_s);
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: out_valid=0 after 20 cycles, required pulse at %0d", name, LAT);
    end else begin
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("FAIL %s latency: got %0d required %0d", name, lat, LAT);
      end
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s out: got %0d required %0d", name, got, exp);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || int'(out_s) !== exp) begin
        errors++;
        $display("FAIL %s hold: out_valid=%0b out=%0d required 0/%0d", name, out_valid, int'(out_s), exp);
      end
    end
    $display("frame %s: out=%0d expected=%0d latency=%0d", name, got, exp, lat);
  endtask

  task automatic run_frame(input int x, input string name, output int got);
    int exp;
    exp = model_frame(x);
    @(negedge clk);
    lr_clk = 1'b1;
    in_s = x[W-1:0];
    wait_result(exp, name, got);
  endtask

  task automatic test_reset();
    int got;
    int exp;
    @(negedge clk);
    rst = 1'b1;
    lr_clk = 1'b1;
    in_s = W'(7);
    repeat (3) @(negedge clk);
    checks++;
    if (out_s !== '0) begin errors++; $display("FAIL reset out: got %0d required 0", out_s); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %0b required 0", out_valid); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset overrun: got %0b required 0", overrun); end
    // lr_clk held high through reset: a frame starts on the first cycle after.
    rst = 1'b0;
    model_reset();
    exp = model_frame(7);
    wait_result(exp, "after_reset", got);
    checks++;
    if (got !== 7) begin errors++; $display("FAIL after_reset const: got %0d required 7", got); end
  endtask

  task automatic test_constant();
    int got;
    int req[3] = '{1, 4, 10};
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      run_frame(1, "constant", got);
      checks++;
      if (got !== req[i]) begin errors++; $display("FAIL constant[%0d]: got %0d required %0d", i, got, req[i]); end
    end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL constant overrun: got %0b required 0", overrun); end
  endtask

  task automatic test_impulse();
    int got;
    int stim[3] = '{5, 0, 0};
    int req[3] = '{5, 15, 30};
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      run_frame(stim[i], "impulse", got);
      checks++;
      if (got !== req[i]) begin errors++; $display("FAIL impulse[%0d]: got %0d required %0d", i, got, req[i]); end
    end
  endtask

  task automatic test_wrap();
    int got;
    int req;
    int stim[4] = '{131072, -131073, -131070, 131071};
    reset_dut();
    // Leaves stage0 = stage1 = 0 and stage2 = MAX without any overflow.
    foreach (stim[i]) run_frame(stim[i], "preload", got);
    checks++;
    if (got !== MAXV) begin errors++; $display("FAIL preload: got %0d required %0d", got, MAXV); end
`ifdef OP_INTEGRATOR_SAT_EN
    req = 262143;
`else
    req = -262144;
`endif
    run_frame(1, "wrap", got);
    checks++;
    if (got !== req) begin errors++; $display("FAIL wrap const: got %0d required %0d", got, req); end
  endtask

  task automatic test_overrun();
    int exp;
    bit seen;
    int lat;
    int extra;
    reset_dut();
    exp = model_frame(3);
    @(negedge clk);
    lr_clk = 1'b1;
    in_s = W'(3);
    seen = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) lr_clk = 1'b0;
      if (n == 2) begin lr_clk = 1'b1; in_s = W'(100); end
      if (n == 3) lr_clk = 1'b0;
      if (out_valid) begin seen = 1'b1; lat = n; end
    end
    checks++;
    if (!seen || lat !== LAT || int'(out_s) !== exp) begin
      errors++;
      $display("FAIL overrun frame: seen=%0b lat=%0d out=%0d required 1/%0d/%0d", seen, lat, int'(out_s), LAT, exp);
    end
    extra = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL overrun dropped: got %0d extra pulses required 0", extra); end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun sticky: got %0b required 1", overrun); end
    $display("frame overrun: out=%0d expected=%0d overrun=%0b", int'(out_s), exp, overrun);
    reset_dut();
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun clear: got %0b required 0", overrun); end
  endtask

  task automatic test_reset_mid_frame();
    int got;
    int pulses;
    reset_dut();
    @(negedge clk);
    lr_clk = 1'b1;
    in_s = W'(9);
    @(posedge clk);
    @(negedge clk);
    lr_clk = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    pulses = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL abort pulses: got %0d required 0", pulses); end
    checks++;
    if (out_s !== '0) begin errors++; $display("FAIL abort out: got %0d required 0", out_s); end
    run_frame(1, "after_abort", got);
    checks++;
    if (got !== 1) begin errors++; $display("FAIL after_abort const: got %0d required 1", got); end
  endtask

  task automatic test_random();
    int got;
    int x;
    logic [W-1:0] r;
    reset_dut();
    for (int i = 0; i < 24; i++) begin
      r = W'($urandom);
      x = int'($signed(r));
      if (i < 8) x = int'($urandom_range(0, 40)) - 20;
      run_frame(x, "random", got);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_constant();
    test_impulse();
    test_wrap();
    test_overrun();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/op_integrator.md
OP_INTEGRATOR -- requirements
Module: op_integrator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 19, giving the sample and accumulator width in two's complement.
REQ-002 The block SHALL have parameter STAGES, default 3, range 1..8, giving the number of cascaded integrator stages.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port lr_clk, input, 1 bit: frame strobe, already synchronous to clk; each rising edge marks one new input sample.
REQ-006 The block SHALL have port in, input, WIDTH bits: signed input sample.
REQ-007 The block SHALL have port out, output, WIDTH bits: signed, registered output of the final stage.
REQ-008 The block SHALL have port out_valid, output, 1 bit: one-cycle pulse marking an updated out.
REQ-009 The block SHALL have port overrun, output, 1 bit: sticky flag set when a frame is dropped; cleared only by rst.

Function
REQ-010 The block SHALL detect a frame start when lr_clk=1 and the registered previous lr_clk=0; prev_lr_clk updates every cycle.
REQ-011 The FSM SHALL have exactly three states: IDLE, ACC and DONE.
REQ-012 In IDLE, on frame start, the block SHALL capture in into a sample register, set stage index k=0, and go to ACC.
REQ-013 In ACC, each cycle SHALL update exactly one stage through one shared adder: acc[0] <= acc[0] + sample; acc[k] <= acc[k] + acc[k-1] for k>0, using the value of acc[k-1] already updated in this frame.
REQ-014 In ACC, k SHALL increment each cycle; after stage STAGES-1 the FSM SHALL go to DONE.
REQ-015 In DONE, the block SHALL load out <= acc[STAGES-1], drive out_valid=1 for that cycle only, and return to IDLE.
REQ-016 Latency SHALL be STAGES+2 cycles from the frame-start cycle to the out_valid cycle (5 cycles for STAGES=3).
REQ-017 A frame start seen in ACC or DONE SHALL be dropped and SHALL set overrun; the frame in progress SHALL complete unaffected.
REQ-018 Without saturation (see Configuration), additions SHALL wrap modulo 2^WIDTH.
REQ-019 out SHALL hold its value between out_valid pulses.

Reset
REQ-020 When rst=1 at a clock edge, the block SHALL clear all acc[], sample, out, out_valid, overrun, k and prev_lr_clk to 0 and set the state to IDLE, in any state.
REQ-021 A reset during ACC SHALL abort the frame, and no out_valid SHALL follow for it.
REQ-022 A frame start can only be detected on the first cycle after reset if lr_clk is then high (prev_lr_clk=0 after reset).

Configuration
REQ-023 The macro OP_INTEGRATOR_SAT_EN, when defined, SHALL make every stage addition saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-024 When OP_INTEGRATOR_SAT_EN is undefined, additions SHALL wrap per REQ-018 and no saturation logic SHALL be synthesized.

Structure
REQ-025 Package op_pkg SHALL hold the WIDTH default, the FSM state enum (IDLE/ACC/DONE), and the signed MAX/MIN saturation constants.
REQ-026 The shared adder, including its optional saturation, SHALL be the single sub-module op_sat_adder (a, b -> sum, WIDTH bits, combinational).

Verification (STAGES=3, WIDTH=19)
REQ-027 Constant input: in=1 on three frames -> out sequence 1, 4, 10, each with a single out_valid pulse 5 cycles after its frame start.
REQ-028 Impulse input: in=5, then 0, then 0 -> out sequence 5, 15, 30.
REQ-029 Wrap/saturate: preload so acc[2]=262143, then a frame with in=1 -> out=-262144 without OP_INTEGRATOR_SAT_EN; out=262143 with it.
REQ-030 Overrun: a second lr_clk rising edge 2 cycles after the first -> first frame output still produced, second sample dropped, overrun=1 until rst.
REQ-031 Reset mid-frame: rst=1 in ACC with k=1 -> out=0, out_valid stays 0, and the next frame with in=1 yields out=1.
